// File: rtl/vga_fb_scheduler.sv
// Framebuffer RAM scheduler: prefetches scanout pixels into a small FIFO and
// hands every RAM cycle not needed for scanout to the game-logic writer.
module vga_fb_scheduler #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WM     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [5:0]        dbg
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  cnt, occ;
  logic              rd_pending;
  logic              fetch_done;
  logic [ADDR_W-1:0] fetch_addr;

  logic read_elig, read_urgent, do_read, do_write, push, pop;

  // occ counts reads still in flight so the FIFO can never be overrun.
  always_comb begin
    occ         = cnt + OCC_W'(rd_pending);
    read_elig   = (occ < OCC_W'(FIFO_DEPTH)) && !fetch_done && !frame_start;
    read_urgent = read_elig && (occ < OCC_W'(LOW_WM));
    do_read     = read_urgent || (read_elig && !wr_req);
    do_write    = wr_req && !read_urgent;
    push        = rd_pending && !frame_start;
    pop         = pix_pop && pix_valid && !frame_start;
    wr_ack      = do_write;
  end

  assign pix_valid = (cnt != '0);
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign dbg       = {underflow, fetch_done, 4'(occ)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      rd_pending <= 1'b0;
      fetch_addr <= '0;
      fetch_done <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      underflow  <= 1'b0;
    end else begin
      ram_we     <= do_write;
      rd_pending <= do_read;
      if (do_write) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end else if (do_read) begin
        ram_addr <= fetch_addr;
      end

      // A read returning during frame_start belongs to the old frame and is dropped.
      if (frame_start) begin
        fetch_addr <= '0;
        fetch_done <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        cnt        <= '0;
      end else begin
        if (do_read) begin
          if (fetch_addr == LAST_ADDR) fetch_done <= 1'b1;
          else                         fetch_addr <= fetch_addr + 1'b1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + OCC_W'(push) - OCC_W'(pop);
      end

      if (pix_pop && !pix_valid && !frame_start) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rdata;
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: a full-size instance for scanout,
// arbitration and frame restart, and a 4x2 instance for end-of-frame behaviour.
module tb_vga_fb_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fs, pop, wreq;
  logic [18:0] waddr;
  logic [7:0]  wdata;
  logic [7:0]  pdata, rwdata, rrdata;
  logic        pvalid, uflow, ack, we;
  logic [18:0] raddr;
  logic [5:0]  dbg;

  logic        s_fs, s_pop, s_wreq;
  logic [18:0] s_waddr;
  logic [7:0]  s_wdata;
  logic [7:0]  s_pdata, s_rwdata, s_rrdata;
  logic        s_pvalid, s_uflow, s_ack, s_we;
  logic [18:0] s_raddr;
  logic [5:0]  s_dbg;

  vga_fb_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(fs), .pix_pop(pop),
    .pix_data(pdata), .pix_valid(pvalid), .underflow(uflow),
    .wr_req(wreq), .wr_addr(waddr), .wr_data(wdata), .wr_ack(ack),
    .ram_addr(raddr), .ram_we(we), .ram_wdata(rwdata), .ram_rdata(rrdata),
    .dbg(dbg)
  );

  vga_fb_scheduler #(.H_ACTIVE(4), .V_ACTIVE(2)) u_small (
    .clk(clk), .rst_n(rst_n), .frame_start(s_fs), .pix_pop(s_pop),
    .pix_data(s_pdata), .pix_valid(s_pvalid), .underflow(s_uflow),
    .wr_req(s_wreq), .wr_addr(s_waddr), .wr_data(s_wdata), .wr_ack(s_ack),
    .ram_addr(s_raddr), .ram_we(s_we), .ram_wdata(s_rwdata), .ram_rdata(s_rrdata),
    .dbg(s_dbg)
  );

  // RAM models: read data follows the registered address, preloaded data[i] = i[7:0].
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];
  assign rrdata   = mem_a[raddr[9:0]];
  assign s_rrdata = mem_b[s_raddr[9:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) begin
        mem_a[i] <= 8'(i);
        mem_b[i] <= 8'(i);
      end
    end else begin
      if (we)   mem_a[raddr[9:0]]   <= rwdata;
      if (s_we) mem_b[s_raddr[9:0]] <= s_rwdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fs, pop, wreq;
    logic [18:0] waddr;
    logic [7:0]  wdata;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_ack, e_we;
    logic [18:0] e_addr;
    logic [7:0]  e_wdata;
    logic [5:0]  e_dbg;
  } vec_t;

  vec_t vt [19];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int npix;
    logic [7:0] pix [8];

    //            fs   pop  wreq waddr   wdata | valid data  ack  we   addr    wdata  dbg
    vt[0]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b0,8'h00,1'b0,1'b0,19'd0,  8'h00,6'b010000};
    vt[1]  = '{1'b0,1'b1,1'b0,19'd0,  8'h00, 1'b0,8'h00,1'b0,1'b0,19'd0,  8'h00,6'b010000};
    vt[2]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b0,8'h00,1'b0,1'b0,19'd0,  8'h00,6'b110000};
    vt[3]  = '{1'b1,1'b1,1'b0,19'd0,  8'h00, 1'b0,8'h00,1'b0,1'b0,19'd0,  8'h00,6'b110000};
    vt[4]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b0,8'h00,1'b0,1'b0,19'd0,  8'h00,6'b100000};
    vt[5]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b0,8'h00,1'b0,1'b0,19'd0,  8'h00,6'b100001};
    vt[6]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd1,  8'h00,6'b100010};
    vt[7]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd2,  8'h00,6'b100011};
    vt[8]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd3,  8'h00,6'b100100};
    vt[9]  = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd4,  8'h00,6'b100101};
    vt[10] = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd5,  8'h00,6'b100110};
    vt[11] = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd6,  8'h00,6'b100111};
    vt[12] = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd7,  8'h00,6'b101000};
    vt[13] = '{1'b0,1'b0,1'b1,19'd100,8'hE0, 1'b1,8'h00,1'b1,1'b0,19'd7,  8'h00,6'b101000};
    vt[14] = '{1'b0,1'b0,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b1,19'd100,8'hE0,6'b101000};
    vt[15] = '{1'b0,1'b1,1'b0,19'd0,  8'h00, 1'b1,8'h00,1'b0,1'b0,19'd100,8'hE0,6'b101000};
    vt[16] = '{1'b0,1'b1,1'b0,19'd0,  8'h00, 1'b1,8'h01,1'b0,1'b0,19'd100,8'hE0,6'b100111};
    vt[17] = '{1'b0,1'b1,1'b0,19'd0,  8'h00, 1'b1,8'h02,1'b0,1'b0,19'd8,  8'hE0,6'b100111};
    vt[18] = '{1'b0,1'b1,1'b0,19'd0,  8'h00, 1'b1,8'h03,1'b0,1'b0,19'd9,  8'hE0,6'b100111};

    rst_n = 1'b0;
    fs = 1'b0; pop = 1'b0; wreq = 1'b0; waddr = '0; wdata = '0;
    s_fs = 1'b0; s_pop = 1'b0; s_wreq = 1'b0; s_waddr = '0; s_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, underflow before any frame, fill, full-FIFO write, drain start.
    for (int i = 0; i < 19; i++) begin
      fs = vt[i].fs; pop = vt[i].pop; wreq = vt[i].wreq;
      waddr = vt[i].waddr; wdata = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(pvalid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_data", i),  32'(pdata),  32'(vt[i].e_data));
      chk($sformatf("v%0d_ack", i),   32'(ack),    32'(vt[i].e_ack));
      chk($sformatf("v%0d_we", i),    32'(we),     32'(vt[i].e_we));
      chk($sformatf("v%0d_addr", i),  32'(raddr),  32'(vt[i].e_addr));
      chk($sformatf("v%0d_wdata", i), 32'(rwdata), 32'(vt[i].e_wdata));
      chk($sformatf("v%0d_dbg", i),   32'(dbg),    32'(vt[i].e_dbg));
      step();
    end
    chk("underflow_pin", 32'(uflow), 32'd1);

    // Continuous popping: raster-order data with no gaps.
    fs = 1'b0; pop = 1'b1; wreq = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("stream%0d", i), 32'({pvalid, pdata}), 32'({1'b1, 8'(4 + i)}));
      step();
    end
    pop = 1'b0;

    // Low occupancy: scanout reads beat a pending write until occ reaches LOW_WM.
    fs = 1'b1;
    step();
    fs = 1'b0; wreq = 1'b1; waddr = 19'd200; wdata = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("lowwm_ack%0d", k), 32'(ack), 32'(k == 4));
      chk($sformatf("lowwm_occ%0d", k), 32'(dbg[3:0]), 32'(k));
      step();
    end
    wreq = 1'b0;

    // Restart while occ=6 with a read in flight: stale data must be dropped.
    n = 0;
    while (dbg[3:0] != 4'd6 && n < 20) begin
      step();
      n++;
    end
    chk("restart_occ6", 32'(dbg[3:0]), 32'd6);
    fs = 1'b1;
    step();
    fs = 1'b0;
    @(negedge clk);
    chk("restart_valid", 32'(pvalid), 32'd0);
    chk("restart_occ", 32'(dbg[3:0]), 32'd0);
    chk("restart_uflow", 32'({uflow, dbg[5]}), 32'b11);
    step();
    @(negedge clk);
    chk("restart_fill", 32'(pvalid), 32'd0);
    step();
    pop = 1'b1;
    @(negedge clk);
    chk("restart_first", 32'({pvalid, pdata}), 32'({1'b1, 8'h00}));
    step();
    @(negedge clk);
    chk("restart_second", 32'({pvalid, pdata}), 32'({1'b1, 8'h01}));
    step();
    pop = 1'b0;

    // 4x2 frame with writer held: 8 reads, then a write every cycle.
    s_fs = 1'b1;
    step();
    s_fs = 1'b0; s_wreq = 1'b1; s_waddr = 19'd500; s_wdata = 8'hAA; s_pop = 1'b1;
    npix = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("small_ack%0d", k), 32'(s_ack), 32'(k >= 8));
      if (k >= 1 && k <= 8)
        chk($sformatf("small_rd%0d", k), 32'({s_we, s_raddr}), 32'({1'b0, 19'(k - 1)}));
      if (k >= 9)
        chk($sformatf("small_wr%0d", k), 32'({s_we, s_raddr}), 32'({1'b1, 19'd500}));
      if (k == 7 || k == 8)
        chk($sformatf("small_done%0d", k), 32'(s_dbg[4]), 32'(k == 8));
      if (s_pvalid) begin
        if (npix < 8) pix[npix] = s_pdata;
        npix++;
      end
      step();
    end
    s_wreq = 1'b0; s_pop = 1'b0;
    chk("small_npix", 32'(npix), 32'd8);
    for (int j = 0; j < 8; j++)
      chk($sformatf("small_pix%0d", j), 32'(pix[j]), 32'(j));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
